// File: rtl/imem_dump_streamer_pkg.sv
// Shared definitions for the instruction-memory dump streamer:
// word/byte geometry, address step and FSM state encoding.
`ifndef CELL_NUMBERS
`define CELL_NUMBERS 1024
`endif

package imem_dump_defs;

  localparam int unsigned INSTR_SIZE     = 32;
  localparam int unsigned BYTE_SIZE      = 8;
  localparam int unsigned BYTES_PER_WORD = INSTR_SIZE / BYTE_SIZE;
  localparam int unsigned ADDR_INCR      = 4;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_READ = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] S_SEND = 3'd3;
  localparam logic [STATE_W-1:0] S_NEXT = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE = 3'd5;

  // Number of whole words that fit in a memory of the given byte size.
  function automatic int unsigned words_in(input int unsigned cells);
    return cells / ADDR_INCR;
  endfunction

endpackage

// File: rtl/imem_dump_streamer_word_serializer.sv
// Holds one instruction word and shifts it out MSB-first, one byte per
// valid/ready transfer; last flags the transfer of the final byte.
module word_serializer
  import imem_dump_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [INSTR_SIZE-1:0] word_in,
  input  logic                  tx_ready,
  output logic [BYTE_SIZE-1:0]  tx_data,
  output logic                  tx_valid,
  output logic                  last
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [INSTR_SIZE-1:0] shreg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  xfer;

  assign xfer    = tx_valid && tx_ready;
  assign tx_data = shreg_q[INSTR_SIZE-1 -: BYTE_SIZE];
  assign last    = xfer && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  // Load a fresh word, or advance one byte on every accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg_q  <= word_in;
      cnt_q    <= '0;
      tx_valid <= 1'b1;
    end else if (xfer) begin
      shreg_q <= {shreg_q[INSTR_SIZE-BYTE_SIZE-1:0], BYTE_SIZE'(0)};
      cnt_q   <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/imem_dump_streamer.sv
// Walks instruction memory from address 0 and streams every word to the
// UART TX as bytes, MSB first. busy holds the core while the dump runs.
module imem_dump_streamer
  import imem_dump_defs::*;
#(
  parameter int unsigned CELL_NUMBERS = `CELL_NUMBERS,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [INSTR_SIZE-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [INSTR_SIZE-1:0] mem_rdata,
  output logic [BYTE_SIZE-1:0]  tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NUM_WORDS = words_in(CELL_NUMBERS);
  localparam int unsigned LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned AW1       = INSTR_SIZE + 1;

  logic [STATE_W-1:0]    state_q, state_d;
  logic [INSTR_SIZE-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  ser_load_c;
  logic                  ser_last;

  // Next-state, address and latency-counter logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    ser_load_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          lat_d   = '0;
          // A memory smaller than one word still yields a done pulse.
          state_d = (NUM_WORDS == 0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
          ser_load_c = 1'b1;
          lat_d      = '0;
          state_d    = S_SEND;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_SEND: begin
        if (ser_last) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        addr_d = addr_q + INSTR_SIZE'(ADDR_INCR);
        // Widened compare so a full-range memory cannot overflow the test.
        state_d = (({1'b0, addr_d} + AW1'(ADDR_INCR)) > AW1'(CELL_NUMBERS)) ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered memory/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      lat_q    <= '0;
      mem_addr <= '0;
      mem_re   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      mem_re  <= (state_d == S_READ);
      if (state_d == S_READ) begin
        mem_addr <= addr_d;
      end
      busy <= (state_d != S_IDLE);
      done <= (state_d == S_DONE);
    end
  end

  word_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load_c),
    .word_in  (mem_rdata),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .last     (ser_last)
  );

endmodule

// File: tb/tb_imem_dump_streamer.sv
// Bench for imem_dump_streamer: four instances cover latency 1/3 and
// memory sizes 8/10/2 bytes; a byte-queue reference model gives the
// expected stream.
module tb_imem_dump_streamer;

  logic        clk;
  logic        rst;
  logic        tx_ready;
  logic [3:0]  start_v;
  logic [3:0]  mem_re_v;
  logic [3:0]  tx_valid_v;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [31:0] mem_addr_v  [4];
  logic [31:0] mem_rdata_v [4];
  logic [7:0]  tx_data_v   [4];
  logic [31:0] pipe        [4][3];
  logic [31:0] mem_words   [4];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // monitor state
  int          sel = 0;
  int          run_id = 0;
  int          seen_id = -1;
  bit          armed = 0;
  bit          ended;
  bit          prev_stall;
  bit          busy_at_done;
  logic [7:0]  prev_data;
  logic [7:0]  got_q[$];
  logic [31:0] addr_q[$];
  logic [7:0]  exp_q[$];
  int          done_cnt, done_cyc, first_valid, stall_err, busy_err, cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_dump_streamer #(.CELL_NUMBERS(8), .READ_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mem_addr(mem_addr_v[0]), .mem_re(mem_re_v[0]),
    .mem_rdata(mem_rdata_v[0]), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
    .tx_ready(tx_ready), .busy(busy_v[0]), .done(done_v[0]));
  imem_dump_streamer #(.CELL_NUMBERS(8), .READ_LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mem_addr(mem_addr_v[1]), .mem_re(mem_re_v[1]),
    .mem_rdata(mem_rdata_v[1]), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
    .tx_ready(tx_ready), .busy(busy_v[1]), .done(done_v[1]));
  imem_dump_streamer #(.CELL_NUMBERS(10), .READ_LATENCY(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mem_addr(mem_addr_v[2]), .mem_re(mem_re_v[2]),
    .mem_rdata(mem_rdata_v[2]), .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]),
    .tx_ready(tx_ready), .busy(busy_v[2]), .done(done_v[2]));
  imem_dump_streamer #(.CELL_NUMBERS(2), .READ_LATENCY(1)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .mem_addr(mem_addr_v[3]), .mem_re(mem_re_v[3]),
    .mem_rdata(mem_rdata_v[3]), .tx_data(tx_data_v[3]), .tx_valid(tx_valid_v[3]),
    .tx_ready(tx_ready), .busy(busy_v[3]), .done(done_v[3]));

  assign mem_rdata_v[0] = pipe[0][0];
  assign mem_rdata_v[1] = pipe[1][2];
  assign mem_rdata_v[2] = pipe[2][0];
  assign mem_rdata_v[3] = pipe[3][0];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a < 32'd16) return mem_words[a[3:2]];
    return 32'hBAD0_BAD0;
  endfunction

  // Memory model: data appears N cycles after mem_re, poison otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      pipe[k][0] <= mem_re_v[k] ? mem_read(mem_addr_v[k]) : 32'hBAD0_BAD0;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  // Observe the selected instance away from the active edge.
  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id = run_id;
      got_q.delete();
      addr_q.delete();
      done_cnt = 0; done_cyc = 0; first_valid = 0; stall_err = 0; busy_err = 0; cyc = 0;
      ended = 0; prev_stall = 0; busy_at_done = 0; prev_data = '0;
    end
    if (armed) cyc++;
    if (mem_re_v[sel]) addr_q.push_back(mem_addr_v[sel]);
    if (tx_valid_v[sel] && tx_ready) got_q.push_back(tx_data_v[sel]);
    if (prev_stall && !(tx_valid_v[sel] && tx_data_v[sel] == prev_data)) stall_err++;
    prev_stall = tx_valid_v[sel] && !tx_ready;
    prev_data  = tx_data_v[sel];
    if (armed && tx_valid_v[sel] && first_valid == 0) first_valid = cyc;
    if (done_v[sel]) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy_v[sel];
      ended        = 1;
    end else if (armed && !ended && !busy_v[sel]) begin
      busy_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cells_of(input int k);
    if (k == 2) return 10;
    if (k == 3) return 2;
    return 8;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  // Reference stream: every whole word, bytes MSB first.
  task automatic build_exp(input int k);
    exp_q.delete();
    for (int w = 0; w < cells_of(k) / 4; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'(mem_words[w] >> (24 - 8 * b)));
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (got_q.size() > i) ? 32'(got_q[i]) : 32'hFFFF_FFFF,
          32'(exp_q[i]));
  endtask

  function automatic logic ready_bit(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // One full dump on instance k; called and returns at posedge+#1.
  task automatic do_dump(input int k, input int mode, input bit repulse, input bit start_at_done);
    bit seen;
    seen     = 0;
    sel      = k;
    run_id++;
    armed    = 0;
    tx_ready = ready_bit(mode, 0);
    start_v  = 4'(1 << k);
    @(posedge clk); #1;
    start_v = '0;
    armed   = 1;
    for (int c = 1; c < 400 && !seen; c++) begin
      tx_ready = ready_bit(mode, c);
      start_v  = (repulse && c == 4) ? 4'(1 << k) : 4'b0;
      if (done_v[k]) begin
        seen = 1;
        if (start_at_done) start_v = 4'(1 << k);
      end
      @(posedge clk); #1;
    end
    start_v  = '0;
    tx_ready = 1'b1;
    chk($sformatf("done_seen_i%0d", k), 32'(seen), 32'd1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    bit got2;
    int k;
    rst      = 1'b1;
    start_v  = '0;
    tx_ready = 1'b1;
    mem_words[0] = 32'hDEADBEEF;
    mem_words[1] = 32'h01020304;
    mem_words[2] = 32'hCAFEF00D;
    mem_words[3] = 32'h55AA55AA;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_mem_addr", mem_addr_v[0], 32'd0);
    chk("rst_mem_re",   32'(mem_re_v[0]), 32'd0);
    chk("rst_tx_data",  32'(tx_data_v[0]), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid_v[0]), 32'd0);
    chk("rst_busy",     32'(busy_v[0]), 32'd0);
    chk("rst_done",     32'(done_v[0]), 32'd0);

    // basic two-word dump, ready held high
    do_dump(0, 0, 0, 0);
    build_exp(0);
    check_bytes("t1");
    chk("t1_re_cnt", 32'(addr_q.size()), 32'd2);
    chk("t1_re_a0", (addr_q.size() > 0) ? addr_q[0] : 32'hFFFF_FFFF, 32'd0);
    chk("t1_re_a1", (addr_q.size() > 1) ? addr_q[1] : 32'hFFFF_FFFF, 32'd4);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_busy_gap", 32'(busy_err), 32'd0);
    chk("t1_busy_at_done", 32'(busy_at_done), 32'd1);
    chk("t1_first_valid", 32'(first_valid), 32'd3);
    chk("t1_done_cyc", 32'(done_cyc), 32'(1 + 2 * (6 + lat_of(0))));
    chk("t1_busy_after", 32'(busy_v[0]), 32'd0);

    // ready toggling 1,0,0
    do_dump(0, 1, 0, 0);
    check_bytes("t2");
    chk("t2_stall", 32'(stall_err), 32'd0);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);

    // start re-pulsed mid-dump and again during the DONE cycle
    do_dump(0, 0, 1, 1);
    check_bytes("t3");
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_re_cnt", 32'(addr_q.size()), 32'd2);
    chk("t3_busy_after", 32'(busy_v[0]), 32'd0);

    // reset after AD accepted
    sel = 0; run_id++; armed = 0; tx_ready = 1'b1; start_v = 4'b0001;
    @(posedge clk); #1;
    start_v = '0; armed = 1; got2 = 0;
    for (int c = 0; c < 50 && !got2; c++) begin
      if (got_q.size() >= 2) got2 = 1;
      else begin @(posedge clk); #1; end
    end
    chk("t4_reach_ad", 32'(got2), 32'd1);
    chk("t4_byte_ad", (got_q.size() > 1) ? 32'(got_q[1]) : 32'hFFFF_FFFF, 32'hAD);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_tx_valid", 32'(tx_valid_v[0]), 32'd0);
    chk("t4_busy", 32'(busy_v[0]), 32'd0);
    chk("t4_mem_re", 32'(mem_re_v[0]), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    chk("t4_idle_busy", 32'(busy_v[0]), 32'd0);
    do_dump(0, 0, 0, 0);
    chk("t4_restart_addr", (addr_q.size() > 0) ? addr_q[0] : 32'hFFFF_FFFF, 32'd0);
    check_bytes("t4r");

    // read latency 3
    do_dump(1, 0, 0, 0);
    build_exp(1);
    check_bytes("t5");
    chk("t5_first_valid", 32'(first_valid), 32'd5);
    chk("t5_done_cyc", 32'(done_cyc), 32'(1 + 2 * (6 + lat_of(1))));

    // 10-byte memory: two words only, addr 8 never read
    do_dump(2, 0, 0, 0);
    build_exp(2);
    check_bytes("t6");
    chk("t6_re_cnt", 32'(addr_q.size()), 32'd2);
    begin
      int hi;
      hi = 0;
      foreach (addr_q[i]) if (addr_q[i] >= 32'd8) hi++;
      chk("t6_no_addr8", 32'(hi), 32'd0);
    end

    // memory smaller than one word: zero-word dump
    do_dump(3, 0, 0, 0);
    chk("t7_done_cnt", 32'(done_cnt), 32'd1);
    chk("t7_bytes", 32'(got_q.size()), 32'd0);
    chk("t7_re_cnt", 32'(addr_q.size()), 32'd0);
    chk("t7_done_cyc", 32'(done_cyc), 32'd1);

    // random memory contents and random tx_ready
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) mem_words[i] = $urandom();
      k = int'($urandom_range(0, 2));
      do_dump(k, 2, 0, 0);
      build_exp(k);
      check_bytes($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_done", r), 32'(done_cnt), 32'd1);
      chk($sformatf("rnd%0d_stall", r), 32'(stall_err), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_dump_streamer.md
Name: imem_dump_streamer

Overview:
Read-side counterpart of the boot-time instruction loader. On a start pulse it walks instruction memory from address 0 in 4-byte steps and reads each 32-bit word. It splits each word into bytes, MSB first, and hands them to the UART transmitter over a valid/ready handshake. It sits between the generic instruction memory's read port and the UART TX, and is used for post-load verification and debug dumps while the core is held (busy drives hang).

Parameters:
INSTR_SIZE, 32, word width read from instruction memory
BYTE_SIZE, 8, width of one transmitted byte
CELL_NUMBERS, `CELL_NUMBERS, memory size in bytes; the dump covers floor(CELL_NUMBERS/4) words
ADDR_INCR, 4, address step per word
READ_LATENCY, 1, cycles from mem_re asserted to mem_rdata valid (1..3)

Ports:
clk  input  1  global clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to begin a dump
mem_addr  output  INSTR_SIZE  byte address to instruction memory
mem_re  output  1  read enable, one-cycle pulse per word
mem_rdata  input  INSTR_SIZE  read data from instruction memory
tx_data  output  BYTE_SIZE  byte offered to UART TX
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART TX accepts the byte this cycle
busy  output  1  dump in progress; drives the CPU hang input
done  output  1  one-cycle pulse when the last byte is accepted

Behaviour:
- Reset values: mem_addr=0, mem_re=0, tx_data=0, tx_valid=0, busy=0, done=0; state=IDLE; word and byte counters=0.
- A reset asserted mid-dump aborts immediately. tx_valid drops on the next edge. No done pulse is produced.
- States:
  - IDLE: start=1 -> READ; busy goes 1 on the same edge.
  - READ: mem_re=1 and mem_addr=current address for exactly one cycle -> WAIT.
  - WAIT: count READ_LATENCY cycles, then capture mem_rdata into the shift register -> SEND.
  - SEND: tx_valid=1, tx_data = word[31:24], then [23:16], [15:8], [7:0]. A byte transfers on an edge where tx_valid && tx_ready. After the 4th transfer -> NEXT.
  - NEXT: address += ADDR_INCR. If new address + 4 > CELL_NUMBERS -> DONE, else -> READ.
  - DONE: done=1 for one cycle, busy=0 on exit -> IDLE.
- Handshake rules:
  - tx_data and tx_valid stay stable while tx_valid && !tx_ready.
  - tx_valid never drops without a transfer, except on rst.
  - Back-to-back bytes are allowed; with tx_ready held high, one byte transfers per cycle.
- Cycle budget per word with tx_ready=1: 1 (READ) + READ_LATENCY (WAIT) + 4 (SEND) + 1 (NEXT).
- With READ_LATENCY=1, word 0 reaches the first tx_valid=1 three edges after start is sampled.
- start while busy is ignored, with no restart and no queuing. start in the same cycle DONE returns to IDLE is also ignored.
- mem_addr holds its last value outside READ; mem_re is 0 outside READ.
- If CELL_NUMBERS < 4, the block still performs a zero-word dump: IDLE -> DONE with a done pulse and no mem_re.
- The address counter is INSTR_SIZE wide and never wraps within a dump.

Decomposition:
- Shared package/header `imem_dump_defs`: state encoding (IDLE, READ, WAIT, SEND, NEXT, DONE) and BYTES_PER_WORD = INSTR_SIZE/BYTE_SIZE.
- Sub-module `word_serializer`: loads a word, shifts it out MSB-first over valid/ready, and pulses `last` on the final byte transfer.
- The top level holds the FSM, address counter and latency counter.

Test Plan:
- Memory preloaded with word0=32'hDEADBEEF, word1=32'h01020304, CELL_NUMBERS=8, tx_ready=1, start pulse -> tx bytes DE AD BE EF 01 02 03 04 on consecutive SEND cycles; mem_re pulses at addr 0 and 4; one done pulse; busy high throughout.
- Same preload, tx_ready toggling 1,0,0,1... -> byte sequence unchanged; tx_data/tx_valid stable during every stall; no byte duplicated or dropped.
- start re-pulsed during the dump of word 0 -> exactly 8 bytes sent and one done pulse.
- rst asserted after byte AD is accepted -> next edge: tx_valid=0, busy=0, state IDLE; a fresh start restarts from addr 0 with DE first.
- READ_LATENCY=3 -> first tx_valid rises 5 edges after start; data matches the word at addr 0.
- CELL_NUMBERS=10 -> exactly 2 words (8 bytes) dumped; addr 8 is never read.
